// File: rtl/uart_rx_parity.sv
// Serial receiver for 8E1 frames (start, 8 data LSB first, even parity, stop).
// Recovers bytes with a one-cycle valid strobe plus parity and framing error flags.
module uart_rx_parity #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data,
    output logic [7:0] bus,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t        state, state_n;
    logic          sync1, data_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_bit_n;
    logic [7:0]    bus_n;
    logic          valid_n, perr_n, ferr_n;

    // valid is a pure strobe with no ready: bus and both error flags change only
    // in the cycle valid is high and hold their values until the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            data_s     <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            bus        <= 8'h00;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= data;
            data_s     <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            par_bit    <= par_bit_n;
            bus        <= bus_n;
            valid      <= valid_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift;
        par_bit_n = par_bit;
        bus_n     = bus;
        valid_n   = 1'b0;
        perr_n    = parity_err;
        ferr_n    = frame_err;
        case (state)
            IDLE: begin
                if (!data_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = data_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    shift_n[idx] = data_s;
                    cnt_n        = '0;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) state_n = PARITY;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (cnt == CNT_FULL) begin
                    par_bit_n = data_s;
                    cnt_n     = '0;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_FULL) begin
                    bus_n   = shift;
                    perr_n  = (^shift) ^ par_bit;
                    ferr_n  = ~data_s;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    // A low stop bit means the line may stay low; wait for it to rise.
                    state_n = data_s ? IDLE : BREAK;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            BREAK: begin
                if (data_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Randomized bench for uart_rx_parity: frames are scored against a byte-level model
// (expected byte, parity error, framing error) plus directed timing and break cases.
module tb_uart_rx_parity;

    localparam int C    = 16;
    localparam int HALF = C / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data;
    logic [7:0] bus;
    logic       valid, parity_err, frame_err, busy;

    uart_rx_parity #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .bus(bus), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard: {frame_err, parity_err, byte}
    logic [9:0] exp_q[$];
    int valid_cnt      = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    int start_cyc      = 0;
    int n_sent         = 0;

    always @(posedge clk) begin
        logic [9:0] e;
        #2;
        if (rst_n && valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bus", {24'd0, bus}, {24'd0, e[7:0]});
                check("parity_err", {31'd0, parity_err}, {31'd0, e[8]});
                check("frame_err", {31'd0, frame_err}, {31'd0, e[9]});
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        exp_q.push_back({~stp, (^b) != par, b});
        n_sent++;
        for (int i = 0; i < 11; i++) begin
            repeat (C) begin
                @(negedge clk);
                if (i == 0 && start_cyc < 0) start_cyc = cyc + 1;
                data = bits[i];
            end
            if (i == 0) start_cyc = start_cyc;
        end
    endtask

    task automatic send_timed(input logic [7:0] b, input logic par, input logic stp);
        start_cyc = -1;
        send_frame(b, par, stp);
    endtask

    initial begin
        int vc;
        logic bad;
        logic saw_busy;
        logic [7:0] rb;
        logic rp, rs;
        int gap;

        // reset then idle
        rst_n = 1'b0;
        data  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bus", {24'd0, bus}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {30'd0, parity_err, frame_err}, 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            data = 1'b1;
            bad  = bad | valid | busy | parity_err | frame_err | (bus != 8'h00);
        end
        check("idle_quiet", {31'd0, bad}, 32'd0);

        // good frame and its sample timing
        send_timed(8'hA5, 1'b0, 1'b1);
        check("good_valid_count", valid_cnt, 1);
        check("good_latency", last_valid_cyc - start_cyc, HALF + 2 + 10 * C);
        check("good_busy_low", {31'd0, busy}, 32'd0);
        idle(2 * C);

        // parity error, then recovery
        send_frame(8'h01, 1'b0, 1'b1);
        check("perr_set", {31'd0, parity_err}, 32'd1);
        idle(2 * C);
        send_frame(8'h03, 1'b0, 1'b1);
        check("perr_clear", {31'd0, parity_err}, 32'd0);
        idle(2 * C);

        // framing error with held-low line
        vc = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40 * C) begin
            @(negedge clk);
            data = 1'b0;
        end
        check("break_busy_high", {31'd0, busy}, 32'd1);
        check("break_one_valid", valid_cnt - vc, 1);
        check("break_ferr", {31'd0, frame_err}, 32'd1);
        idle(2 * C);
        check("break_busy_low", {31'd0, busy}, 32'd0);
        check("break_no_second_valid", valid_cnt - vc, 1);

        // glitch rejection
        vc = valid_cnt;
        repeat (3) begin
            @(negedge clk);
            data = 1'b0;
        end
        saw_busy = 1'b0;
        repeat (2 * C) begin
            @(negedge clk);
            data = 1'b1;
            saw_busy = saw_busy | busy;
        end
        check("glitch_busy_pulse", {31'd0, saw_busy}, 32'd1);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", valid_cnt - vc, 0);

        // reset during data bit 4
        vc = valid_cnt;
        rb = 8'h77;
        repeat (C) begin
            @(negedge clk);
            data = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            repeat (C) begin
                @(negedge clk);
                data = rb[i];
            end
        end
        repeat (HALF) begin
            @(negedge clk);
            data = rb[4];
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_bus", {24'd0, bus}, 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_flags", {30'd0, parity_err, frame_err}, 32'd0);
        rst_n = 1'b1;
        data  = 1'b1;
        idle(3 * C);
        check("midrst_no_valid", valid_cnt - vc, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("after_rst_valid", valid_cnt - vc, 1);
        idle(2 * C);

        // back-to-back frames
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1);
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 11 * C);
        idle(2 * C);

        // random frames with random parity / stop faults and gaps
        for (int k = 0; k < 24; k++) begin
            rb  = 8'($urandom_range(0, 255));
            rp  = (^rb) ^ ($urandom_range(0, 3) == 0);
            rs  = ($urandom_range(0, 4) != 0);
            gap = rs ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(rb, rp, rs);
            idle(gap * C);
        end
        idle(C);

        // drain with a bounded wait
        for (int t = 0; t < 4 * C && exp_q.size() != 0; t++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        check("valid_total", valid_cnt, n_sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- Serial receiver that sits directly downstream of the team's parity transmitter and consumes its `data` line.
- Frame format:
  - idle high;
  - one start bit (0);
  - 8 data bits, LSB first;
  - one even-parity bit (XOR of the 8 data bits);
  - one stop bit (1).
- Recovers the byte onto a parallel bus with a one-cycle valid strobe, plus parity and framing error flags.
- Fully synchronous: one clock domain, no `#` delays.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Legal values are even and >= 4; other values are unsupported.
- HALF_BIT, CLKS_PER_BIT/2: derived; cycles from detected start edge to mid-bit sample.

Ports:
- clk  input  1  system clock, rising edge only.
- rst_n  input  1  synchronous reset, active low.
- data  input  1  serial line from the transmitter; idle high; asynchronous to clk.
- bus  output  8  last received byte.
- valid  output  1  one-cycle strobe: bus, parity_err and frame_err are updated.
- parity_err  output  1  last frame failed even parity; qualified by valid, held until next frame.
- frame_err  output  1  last frame had stop bit = 0; qualified by valid, held until next frame.
- busy  output  1  receiver is not in IDLE.

Behaviour:
- Reset, sampled on the rising clk edge while rst_n=0:
  - state=IDLE, all counters 0, both synchroniser flops = 1, bus=8'h00.
  - valid=0, parity_err=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame silently; no valid is issued.
- Input synchroniser: two flops on data, producing data_s. Latency is 2 cycles. All decisions use data_s only.
- Bit counter: cnt, width $clog2(CLKS_PER_BIT). Bit index: idx, 3 bits.
- IDLE:
  - If data_s=0, go to START with cnt=0.
  - busy rises in the cycle after the transition.
- START:
  - Increment cnt until cnt==HALF_BIT-1, then sample data_s.
  - data_s=1: false start (glitch). Go to IDLE, no flags, no valid.
  - data_s=0: go to DATA with cnt=0, idx=0.
- DATA:
  - When cnt==CLKS_PER_BIT-1, set shift[idx]=data_s, cnt=0, idx++.
  - After idx 7 is sampled, go to PARITY.
- PARITY: when cnt==CLKS_PER_BIT-1, capture par_bit=data_s, cnt=0, go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1, in the same edge:
  - bus<=shift.
  - parity_err <= ^shift ^ par_bit.
  - frame_err <= ~data_s.
  - valid<=1.
  - Go to IDLE if data_s=1, else go to BREAK.
- BREAK: wait until data_s=1, then go to IDLE. This prevents a held-low line from re-triggering START.
- valid:
  - High for exactly one cycle per completed frame.
  - Issued even when an error flag is set.
  - Never issued for a false start or an aborted frame.
- bus and the error flags are held between frames.
- Timing: edge 0 is the first rising edge at which data is low for a start bit.
  - Sample points:
    - start sampled at edge HALF_BIT+2;
    - data bit i at edge HALF_BIT+2+(i+1)*CLKS_PER_BIT;
    - parity at edge HALF_BIT+2+9*CLKS_PER_BIT;
    - stop at edge HALF_BIT+2+10*CLKS_PER_BIT.
  - valid is high in the cycle following the stop-sample edge.
  - Back-to-back frames: a start bit immediately after the stop bit is detected correctly, because IDLE is re-entered half a bit before the stop bit ends.
- busy=1 in START, DATA, PARITY, STOP and BREAK.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 3 cycles, release, data=1 for 200 cycles.
  - Response: bus=00, valid/busy/parity_err/frame_err=0 throughout.
- Good frame, CLKS_PER_BIT=16:
  - Stimulus: send 0xA5 with parity 0 and stop 1.
  - Response: one valid pulse, observed after edge 170; bus=A5, parity_err=0, frame_err=0; busy low again after the pulse.
- Parity error:
  - Stimulus: send 0x01 with parity forced to 0.
  - Response: valid pulse; bus=01, parity_err=1, frame_err=0.
  - Follow-up: then send 0x03 with parity 0; parity_err returns to 0.
- Framing error and break:
  - Stimulus: send 0x3C with stop=0, line held low for 40 further bit times, then high.
  - Response: single valid pulse; bus=3C, frame_err=1; busy stays high until the line returns high; no second valid.
- Glitch and reset:
  - Glitch stimulus: 3-cycle low pulse on data.
  - Glitch response: busy pulses, then returns low; no valid.
  - Reset stimulus: rst_n=0 asserted during data bit 4 of a frame.
  - Reset response: outputs go to reset values at that edge; no valid; the next full frame 0x5A is received correctly.
- Back-to-back frames:
  - Stimulus: frames 0xFF then 0x00, with zero idle bits between them.
  - Response: two valid pulses exactly 11*CLKS_PER_BIT cycles apart; bus=FF then 00; both with no errors.
